// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
//   Bundles the three buses that meet at the data-memory arbiter:
//     cpu_*  : pipelined CPU memory stage (lw/sw), load data and stall back
//     io_*   : IO/loader master request, grant pulse and registered read data
//     mem_*  : single-port dmem (combinational read, write on clock edge)
//   Modports:
//     slave  : the arbiter's view (takes CPU/IO requests, drives dmem)
//     master : the surrounding environment's view (CPU, IO master and dmem)
interface dmem_port_arbiter_if #(
    parameter int MEM_AW = 6
);
    // CPU memory stage
    logic              cpu_en;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wd;
    logic [31:0]       cpu_rd;
    logic              cpu_stall;

    // IO / loader master
    logic              io_req;
    logic              io_we;
    logic [31:0]       io_addr;
    logic [31:0]       io_wd;
    logic              io_gnt;
    logic              io_rvalid;
    logic [31:0]       io_rdata;

    // dmem
    logic              mem_we;
    logic [MEM_AW-1:0] mem_a;
    logic [31:0]       mem_d;
    logic [31:0]       mem_q;

    modport slave (
        input  cpu_en, cpu_we, cpu_addr, cpu_wd,
        output cpu_rd, cpu_stall,
        input  io_req, io_we, io_addr, io_wd,
        output io_gnt, io_rvalid, io_rdata,
        output mem_we, mem_a, mem_d,
        input  mem_q
    );

    modport master (
        output cpu_en, cpu_we, cpu_addr, cpu_wd,
        input  cpu_rd, cpu_stall,
        output io_req, io_we, io_addr, io_wd,
        input  io_gnt, io_rvalid, io_rdata,
        input  mem_we, mem_a, mem_d,
        output mem_q
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port data memory between the CPU memory stage and an
//   IO/loader master. The CPU normally wins; an IO request that has waited
//   STARVE_LIMIT cycles is granted anyway and the CPU is stalled for that one
//   cycle. IO reads return registered data one cycle after the grant.
//   Ports:
//     clk  : system clock, all state on the rising edge
//     rst  : asynchronous active-low reset
//     bus  : dmem_port_arbiter_if.slave (cpu_*, io_*, mem_* signals)
//   Parameters:
//     MEM_AW       : dmem word-address width; must match the interface instance
//     STARVE_LIMIT : IO wait cycles before a forced grant, legal range 1..15
module dmem_port_arbiter #(
    parameter int MEM_AW       = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_port_arbiter_if.slave    bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    // One memory access as presented to dmem.
    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] a;
        logic [31:0]       d;
    } mem_req_t;

    logic [CW-1:0] starve_cnt;
    logic          force_gnt;
    logic          io_gnt;
    logic          io_rd_gnt;
    mem_req_t      cpu_side;
    mem_req_t      io_side;
    mem_req_t      mem_req;
    logic          io_rvalid;
    logic [31:0]   io_rdata;

    // Force comes from the register only, so the grant decision never
    // depends on the request it is deciding about.
    assign force_gnt = (starve_cnt == LIMIT);
    assign io_gnt    = bus.io_req & (~bus.cpu_en | force_gnt);
    assign io_rd_gnt = io_gnt & ~bus.io_we;

    // Word addressing: bits [1:0] and everything above MEM_AW+1 alias.
    assign cpu_side.we = bus.cpu_en & bus.cpu_we;
    assign cpu_side.a  = bus.cpu_addr[MEM_AW+1:2];
    assign cpu_side.d  = bus.cpu_wd;

    assign io_side.we  = bus.io_we;
    assign io_side.a   = bus.io_addr[MEM_AW+1:2];
    assign io_side.d   = bus.io_wd;

    // A CPU store that loses to a forced IO grant simply does not reach
    // dmem; the stalled pipeline re-presents it the next cycle.
    assign mem_req = io_gnt ? io_side : cpu_side;

    assign bus.mem_we    = mem_req.we;
    assign bus.mem_a     = mem_req.a;
    assign bus.mem_d     = mem_req.d;

    assign bus.cpu_rd    = bus.mem_q;
    assign bus.cpu_stall = bus.cpu_en & io_gnt;
    assign bus.io_gnt    = io_gnt;
    assign bus.io_rvalid = io_rvalid;
    assign bus.io_rdata  = io_rdata;

    // Starvation counter: cleared by any grant or by the IO withdrawing its
    // request, otherwise counts waiting cycles up to the limit. Because a
    // forced grant clears it, the CPU always gets at least STARVE_LIMIT
    // cycles between forced grants.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (io_gnt || !bus.io_req) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // IO read return: one-stage valid, data captured from dmem in the
    // grant cycle and held until the next IO read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_rvalid <= 1'b0;
            io_rdata  <= '0;
        end else begin
            io_rvalid <= io_rd_gnt;
            if (io_rd_gnt)
                io_rdata <= bus.mem_q;
        end
    end

    // Address bits that alias away by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.cpu_addr[31:MEM_AW+2], bus.cpu_addr[1:0],
                                bus.io_addr[31:MEM_AW+2],  bus.io_addr[1:0]};

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Directed vectors against dmem_port_arbiter with a behavioural dmem
//   (combinational read, write on rising edge). Expected values are
//   hand-computed constants.
module tb_dmem_port_arbiter;

    localparam int MEM_AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mem [2**MEM_AW];

    dmem_port_arbiter_if #(.MEM_AW(MEM_AW)) b ();

    dmem_port_arbiter #(.MEM_AW(MEM_AW), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    assign b.mem_q = mem[b.mem_a];

    always @(posedge clk)
        if (b.mem_we)
            mem[b.mem_a] <= b.mem_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic ce, input logic cw, input logic [31:0] ca,
                          input logic [31:0] cd, input logic ir, input logic iw,
                          input logic [31:0] ia, input logic [31:0] id);
        b.cpu_en = ce; b.cpu_we = cw; b.cpu_addr = ca; b.cpu_wd = cd;
        b.io_req = ir; b.io_we  = iw; b.io_addr  = ia; b.io_wd  = id;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2**MEM_AW; i++) mem[i] = '0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

        // power-up reset
        #1 rst = 1'b0;
        #1;
        chk("rst_rvalid", b.io_rvalid, 0);
        chk("rst_rdata",  b.io_rdata,  0);
        chk("rst_gnt",    b.io_gnt,    0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();

        // CPU store then load, plus aliasing of upper/low address bits
        set_in(1, 1, 32'h14, 32'hDEADBEEF, 0, 0, 0, 0);
        #2;
        chk("cpu_sw_we",    b.mem_we,    1);
        chk("cpu_sw_a",     b.mem_a,     5);
        chk("cpu_sw_d",     b.mem_d,     32'hDEADBEEF);
        chk("cpu_sw_stall", b.cpu_stall, 0);
        tick();
        set_in(1, 0, 32'h14, 0, 0, 0, 0, 0);
        #2;
        chk("cpu_lw_we", b.mem_we, 0);
        chk("cpu_lw_rd", b.cpu_rd, 32'hDEADBEEF);
        set_in(1, 0, 32'h1000_0017, 0, 0, 0, 0, 0);
        #1;
        chk("alias_a",  b.mem_a,  5);
        chk("alias_rd", b.cpu_rd, 32'hDEADBEEF);
        tick();

        // IO read with CPU idle: same-cycle grant, data next cycle
        set_in(0, 0, 0, 0, 1, 0, 32'h14, 0);
        #2;
        chk("io_idle_gnt", b.io_gnt, 1);
        chk("io_idle_a",   b.mem_a,  5);
        chk("io_idle_we",  b.mem_we, 0);
        tick();
        chk("io_idle_rvalid", b.io_rvalid, 1);
        chk("io_idle_rdata",  b.io_rdata,  32'hDEADBEEF);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        tick();
        chk("io_idle_rvalid_off", b.io_rvalid, 0);
        chk("io_idle_rdata_hold", b.io_rdata,  32'hDEADBEEF);

        // Starvation: CPU reads every cycle, IO write pending -> forced grants at 4 and 9
        for (int c = 0; c <= 10; c++) begin
            logic g;
            g = (c == 4) || (c == 9);
            set_in(1, 0, 32'h0, 0, 1, 1, 32'h20, 32'h55);
            #2;
            chk($sformatf("starve_gnt_c%0d", c),   b.io_gnt,    g);
            chk($sformatf("starve_stall_c%0d", c), b.cpu_stall, g);
            chk($sformatf("starve_a_c%0d", c),     b.mem_a,     g ? 8 : 0);
            chk($sformatf("starve_we_c%0d", c),    b.mem_we,    g);
            if (g) chk($sformatf("starve_d_c%0d", c), b.mem_d, 32'h55);
            tick();
            if (c == 4) chk("starve_wr_no_rvalid", b.io_rvalid, 0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        tick();

        // Stalled CPU store suppressed during forced IO read of the same word
        for (int c = 0; c < 4; c++) begin
            set_in(1, 0, 32'h0, 0, 1, 0, 32'h20, 0);
            #2;
            chk($sformatf("sup_wait_gnt_c%0d", c), b.io_gnt, 0);
            tick();
        end
        set_in(1, 1, 32'h20, 32'h11, 1, 0, 32'h20, 0);
        #2;
        chk("sup_gnt",   b.io_gnt,    1);
        chk("sup_stall", b.cpu_stall, 1);
        chk("sup_we",    b.mem_we,    0);
        chk("sup_a",     b.mem_a,     8);
        tick();
        chk("sup_rvalid", b.io_rvalid, 1);
        chk("sup_rdata",  b.io_rdata,  32'h55);
        set_in(1, 1, 32'h20, 32'h11, 0, 0, 0, 0);
        #2;
        chk("sup_retry_we",    b.mem_we,    1);
        chk("sup_retry_a",     b.mem_a,     8);
        chk("sup_retry_d",     b.mem_d,     32'h11);
        chk("sup_retry_stall", b.cpu_stall, 0);
        tick();
        chk("sup_retry_rvalid", b.io_rvalid, 0);
        set_in(1, 0, 32'h20, 0, 0, 0, 0, 0);
        #2;
        chk("sup_landed", b.cpu_rd, 32'h11);
        tick();

        // Back-to-back IO reads of words 0 and 1
        set_in(1, 1, 32'h0, 32'hA0A00001, 0, 0, 0, 0);
        #2;
        tick();
        set_in(1, 1, 32'h4, 32'hB0B00002, 0, 0, 0, 0);
        #2;
        tick();
        set_in(0, 0, 0, 0, 1, 0, 32'h0, 0);
        #2;
        chk("b2b_gnt0", b.io_gnt, 1);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 32'h4, 0);
        #2;
        chk("b2b_gnt1",    b.io_gnt,    1);
        chk("b2b_rvalid0", b.io_rvalid, 1);
        chk("b2b_rdata0",  b.io_rdata,  32'hA0A00001);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("b2b_gnt_off", b.io_gnt,    0);
        chk("b2b_rvalid1", b.io_rvalid, 1);
        chk("b2b_rdata1",  b.io_rdata,  32'hB0B00002);
        tick();
        chk("b2b_rvalid_off", b.io_rvalid, 0);

        // IO withdraws after 3 waits: counter clears, next grant 4 waits later
        for (int c = 0; c <= 8; c++) begin
            logic r;
            r = (c != 3);
            set_in(1, 0, 32'h0, 0, r, 0, 32'h4, 0);
            #2;
            chk($sformatf("wd_gnt_c%0d", c), b.io_gnt, c == 8);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        tick();

        // Async reset mid-cycle with counter at 3 and io_rdata non-zero
        for (int c = 0; c < 3; c++) begin
            set_in(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
            #2;
            tick();
        end
        chk("pre_rst_rdata", b.io_rdata, 32'hB0B00002);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_rvalid", b.io_rvalid, 0);
        chk("mid_rst_rdata",  b.io_rdata,  0);
        tick();
        rst = 1'b1;
        // counter restarted from 0: grant only on the 5th waiting cycle
        for (int c = 0; c <= 4; c++) begin
            set_in(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
            #2;
            chk($sformatf("post_rst_gnt_c%0d", c), b.io_gnt, c == 4);
            tick();
        end
        chk("post_rst_rvalid", b.io_rvalid, 1);
        chk("post_rst_rdata",  b.io_rdata,  32'hB0B00002);

        // Read granted just before reset loses its rvalid
        set_in(0, 0, 0, 0, 1, 0, 32'h0, 0);
        #2;
        chk("late_gnt", b.io_gnt, 1);
        @(posedge clk);
        rst = 1'b0;
        #1;
        chk("late_rvalid", b.io_rvalid, 0);
        chk("late_rdata",  b.io_rdata,  0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
